// File: rtl/m_code_acq_ctrl_pkg.sv
// Definitions shared by the M-code acquisition controller and the M-code generator.
package m_code_acq_ctrl_pkg;

    localparam int CLKS_PER_CHIP_DEF = 3052;
    localparam int SEQ_LEN_DEF       = 2047;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        SLIP   = 2'd2,
        LOCKED = 2'd3
    } acq_state_e;

    // Width of a counter that holds 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/m_corr_accum.sv
// Chip-phase tracker and +/-1 sliding correlator over one code period.
module m_corr_accum
    import m_code_acq_ctrl_pkg::*;
#(
    parameter int CLKS_PER_CHIP = CLKS_PER_CHIP_DEF,
    parameter int SAMPLE_PHASE  = 1526,
    parameter int SEQ_LEN       = SEQ_LEN_DEF,
    parameter int ACC_W         = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accum_en,
    input  logic             slip,
    input  logic             rx_code,
    input  logic             local_code,
    output logic             chip_last,
    output logic             win_end,
    output logic [ACC_W-1:0] win_sum,
    output logic [ACC_W-1:0] corr_value,
    output logic             corr_valid
);

    localparam int PH_W = cnt_w(CLKS_PER_CHIP);
    localparam int IX_W = cnt_w(SEQ_LEN);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_CHIP - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [IX_W-1:0] IX_LAST   = IX_W'(SEQ_LEN - 1);
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

    logic [PH_W-1:0]         phase_cnt;
    logic [IX_W-1:0]         chip_idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_step;
    logic                    sample;

    assign chip_last = (phase_cnt == PH_LAST);
    assign sample    = accum_en && (phase_cnt == PH_SAMPLE);
    assign win_end   = sample && (chip_idx == IX_LAST);
    assign win_sum   = acc_step;

    always_comb begin
        acc_step = acc;
        if (rx_code == local_code) begin
            if (acc != ACC_MAX) acc_step = acc + ACC_ONE;
        end else begin
            if (acc != ACC_MIN) acc_step = acc - ACC_ONE;
        end
    end

    // Phase free-runs in every state so it stays aligned with the generator's chip clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt  <= '0;
            chip_idx   <= '0;
            acc        <= '0;
            corr_value <= '0;
            corr_valid <= 1'b0;
        end else begin
            if (slip || chip_last) phase_cnt <= '0;
            else                   phase_cnt <= phase_cnt + 1'b1;

            corr_valid <= 1'b0;
            if (clear) begin
                acc      <= '0;
                chip_idx <= '0;
            end else if (sample) begin
                if (win_end) begin
                    corr_value <= acc_step;
                    corr_valid <= 1'b1;
                    acc        <= '0;
                    chip_idx   <= '0;
                end else begin
                    acc      <= acc_step;
                    chip_idx <= chip_idx + 1'b1;
                end
            end
        end
    end

    acc_never_saturates_a: assert property (@(posedge clk) disable iff (!rst_n)
        (acc != ACC_MAX) && (acc != ACC_MIN));

endmodule

// File: rtl/m_code_acq_ctrl.sv
// Code-acquisition FSM: searches by slipping the local M-code one chip per failed window,
// declares lock on a strong correlation and drops it after repeated weak windows.
//   state  | meaning
//   IDLE   | disabled, counters cleared
//   SEARCH | correlating a full window at the current code offset
//   SLIP   | waiting for chip end to pulse shift_parse
//   LOCKED | tracking; consecutive weak windows drop lock
module m_code_acq_ctrl
    import m_code_acq_ctrl_pkg::*;
#(
    parameter int CLKS_PER_CHIP = CLKS_PER_CHIP_DEF,
    parameter int SAMPLE_PHASE  = 1526,
    parameter int SEQ_LEN       = SEQ_LEN_DEF,
    parameter int LOCK_THRESH   = 1800,
    parameter int LOSS_THRESH   = 1024,
    parameter int MISS_MAX      = 3,
    parameter int ACC_W         = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             rx_code,
    input  logic             local_code,
    output logic             shift_parse,
    output logic             locked,
    output logic [ACC_W-1:0] corr_value,
    output logic             corr_valid,
    output logic [10:0]      slip_count,
    output logic             search_fail
);

    localparam int MISS_W = cnt_w(MISS_MAX + 1);
    localparam logic [10:0]             SLIP_LAST = 11'(SEQ_LEN - 1);
    localparam logic [MISS_W-1:0]       MISS_LAST = MISS_W'(MISS_MAX - 1);
    localparam logic signed [ACC_W-1:0] LOCK_T    = ACC_W'(LOCK_THRESH);
    localparam logic signed [ACC_W-1:0] LOSS_T    = ACC_W'(LOSS_THRESH);

    acq_state_e              state;
    acq_state_e              state_nxt;
    logic                    locked_nxt;
    logic                    fail_nxt;
    logic [10:0]             slip_nxt;
    logic [MISS_W-1:0]       miss_cnt;
    logic [MISS_W-1:0]       miss_nxt;
    logic                    chip_last;
    logic                    win_end;
    logic [ACC_W-1:0]        win_sum;
    logic signed [ACC_W-1:0] win_sum_s;
    logic                    accum_en;
    logic                    accum_clear;

    assign win_sum_s   = $signed(win_sum);
    assign accum_en    = (state == SEARCH) || (state == LOCKED);
    assign accum_clear = !enable || (state == IDLE);

    m_corr_accum #(
        .CLKS_PER_CHIP (CLKS_PER_CHIP),
        .SAMPLE_PHASE  (SAMPLE_PHASE),
        .SEQ_LEN       (SEQ_LEN),
        .ACC_W         (ACC_W)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accum_clear),
        .accum_en   (accum_en),
        .slip       (shift_parse),
        .rx_code    (rx_code),
        .local_code (local_code),
        .chip_last  (chip_last),
        .win_end    (win_end),
        .win_sum    (win_sum),
        .corr_value (corr_value),
        .corr_valid (corr_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            locked      <= 1'b0;
            slip_count  <= '0;
            miss_cnt    <= '0;
            search_fail <= 1'b0;
        end else begin
            state       <= state_nxt;
            locked      <= locked_nxt;
            slip_count  <= slip_nxt;
            miss_cnt    <= miss_nxt;
            search_fail <= fail_nxt;
        end
    end

    // Lock decisions use the window sum at the final sample so locked rises with corr_valid.
    always_comb begin
        state_nxt   = state;
        locked_nxt  = locked;
        slip_nxt    = slip_count;
        miss_nxt    = miss_cnt;
        fail_nxt    = search_fail;
        shift_parse = 1'b0;
        if (!enable) begin
            state_nxt  = IDLE;
            locked_nxt = 1'b0;
            slip_nxt   = '0;
            miss_nxt   = '0;
            fail_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: state_nxt = SEARCH;
                SEARCH: begin
                    if (win_end) begin
                        if (win_sum_s >= LOCK_T) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                            miss_nxt   = '0;
                        end else begin
                            state_nxt = SLIP;
                        end
                    end
                end
                SLIP: begin
                    if (chip_last) begin
                        shift_parse = 1'b1;
                        state_nxt   = SEARCH;
                        if (slip_count == SLIP_LAST) begin
                            slip_nxt = '0;
                            fail_nxt = 1'b1;
                        end else begin
                            slip_nxt = slip_count + 11'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (win_end) begin
                        if (win_sum_s < LOSS_T) begin
                            if (miss_cnt == MISS_LAST) begin
                                state_nxt  = SEARCH;
                                locked_nxt = 1'b0;
                                miss_nxt   = '0;
                                slip_nxt   = '0;
                            end else begin
                                miss_nxt = miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_nxt = '0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    shift_parse_single_a: assert property (@(posedge clk) disable iff (!rst_n)
        shift_parse |=> !shift_parse);

endmodule

// File: doc/m_code_acq_ctrl.md
Name: m_code_acq_ctrl

Overview:
Sliding-correlator code-acquisition controller sitting directly downstream of the 11-stage M-code generator (2047-chip period, one chip per 3052 clk).
- Samples the received chip stream and the generator's local m_code mid-chip, and correlates them over one full code period.
- When the correlation is below threshold, it drives the generator's one-chip-delay input (shift_parse) to slip the local code; on success it declares lock and then tracks lock loss.
- It is therefore both consumer of m_code and producer of shift_parse.

Parameters:
CLKS_PER_CHIP, 3052, clocks per chip; must match the generator.
SAMPLE_PHASE, 1526, phase-counter value at which both chips are sampled.
SEQ_LEN, 2047, chips per correlation window.
LOCK_THRESH, 1800, signed correlation at or above which the block declares lock.
LOSS_THRESH, 1024, in LOCKED, a window below this counts as a miss.
MISS_MAX, 3, consecutive misses that drop lock.
ACC_W, 13, signed accumulator width; must hold ±SEQ_LEN.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 0 holds the block in IDLE
rx_code  in  1  received hard-decision chip, synchronous to clk
local_code  in  1  m_code from the generator
shift_parse  out  1  one-cycle pulse requesting a one-chip delay of the local code
locked  out  1  code lock flag
corr_value  out  ACC_W  signed correlation of the last completed window
corr_valid  out  1  one-cycle pulse when corr_value updates
slip_count  out  11  slips since the search started (0..SEQ_LEN-1)
search_fail  out  1  sticky; a full sweep produced no lock; cleared by enable=0 or reset

Behaviour:
- Reset: rst_n is asynchronous, active-low. All outputs are 0, state is IDLE, all counters are 0.
- Phase counter:
  - phase_cnt counts 0..CLKS_PER_CHIP-1 and wraps.
  - It is forced to 0 in the same cycle shift_parse=1, mirroring the generator's counter clear.
- Sampling: when phase_cnt==SAMPLE_PHASE in an accumulating state:
  - acc += +1 if rx_code==local_code, else −1.
  - chip_idx increments.
- Window end: the sample with chip_idx==SEQ_LEN-1.
  - Next cycle: corr_value<=final acc and corr_valid=1 for 1 cycle.
  - acc and chip_idx clear, so the next window starts with no gap.
- States:
  - IDLE: counters cleared, locked=0. enable=1 → SEARCH.
  - SEARCH: accumulate. At window end:
    - acc>=LOCK_THRESH → LOCKED, with locked=1 in the cycle corr_valid fires.
    - Otherwise → SLIP.
  - SLIP:
    - Wait until phase_cnt==CLKS_PER_CHIP-1, then assert shift_parse for exactly 1 cycle and increment slip_count.
    - If slip_count was SEQ_LEN-1, instead set search_fail=1, set slip_count=0 and still pulse shift_parse.
    - → SEARCH. Samples are not accumulated while in SLIP.
  - LOCKED: accumulate continuously.
    - Window acc<LOSS_THRESH → miss_cnt++; otherwise miss_cnt=0.
    - miss_cnt reaching MISS_MAX → locked=0, miss_cnt=0, slip_count=0 → SEARCH. No slip is issued on lock loss.
- enable=0 in any state → IDLE next cycle.
  - An in-flight window is discarded without corr_valid.
  - search_fail clears.
  - shift_parse is never asserted in the same cycle enable=0 is sampled.
- shift_parse is never high for 2 consecutive cycles and is only asserted from SLIP.
- The accumulator saturates at ±(2^(ACC_W-1)-1). This is unreachable with legal parameters and must be covered by an assertion.
- Mid-operation reset: immediate return to reset values; no partial-window output.

Decomposition:
- Shared package: state enum (IDLE, SEARCH, SLIP, LOCKED), default constants CLKS_PER_CHIP=3052 and SEQ_LEN=2047, shared with the generator.
- Sub-module: m_corr_accum (phase counter, sample strobe, ±1 accumulator, chip_idx, corr_valid).
- The FSM stays in the top.

Test Plan:
All scenarios use CLKS_PER_CHIP=8, SAMPLE_PHASE=4, SEQ_LEN=2047, with the generator instantiated and fed by this block's shift_parse.
- rx_code driven from an identical, aligned generator → first corr_valid shows corr_value=2047, locked=1, zero shift_parse pulses, slip_count=0.
- rx_code delayed by 5 chips relative to local → exactly 5 shift_parse pulses, each 1 cycle wide and spaced ≥1 window apart; corr_value=−1 on each miss window, then 2047 with locked=1, slip_count=5.
- rx_code held constant 0 → no lock; after 2047 slips search_fail=1, slip_count wraps to 0, search continues.
- After lock, invert rx_code → corr_value=−2047 for 3 windows; locked drops at the 3rd corr_valid, state returns to SEARCH with no extra shift_parse.
- Deassert rst_n mid-window (chip_idx≈1000) → all outputs 0 immediately. After release, the first corr_valid arrives a full SEQ_LEN chips later with no partial value.
- enable=0 during SLIP wait → no shift_parse, state IDLE next cycle, search_fail cleared. Re-enable restarts the search from slip_count=0.
